// File: rtl/gpio_input_filter.sv
// Purpose : per-pin pad conditioner (2-flop sync + optional prescaled debounce) feeding the GPIO controller.
// Latency : bypass 2 edges after capture; filtered 2 + db_count..db_count+1 prescaler periods + 1.
// Backpressure: none; a free-running level path that cannot stall.
//
// Ports:
//   PCLK, PRESETn            - only clock (rising edge) and async active-low reset
//   pad_in[WIDTH]            - raw asynchronous pad levels
//   db_en[WIDTH]             - 1 = debounce the pin, 0 = synchronize only
//   db_prescale[PRE_W]       - debounce sample tick every db_prescale+1 cycles
//   db_count[CNT_W]          - a new level must persist for db_count+1 ticks
//   gpio_in[WIDTH]           - conditioned, registered level
//   gpio_chg[WIDTH]          - one-cycle pulse in the first cycle gpio_in shows a new value
module gpio_input_filter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] db_en,
  input  logic [PRE_W-1:0] db_prescale,
  input  logic [CNT_W-1:0] db_count,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_chg
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [PRE_W-1:0] pcnt;
  logic             tick;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] gpio_in_next;

  // Two-flop synchronizer; nothing may sit between s1 and s2.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_in;
      s2 <= s1;
    end
  end

  // Shared prescaler. The >= compare means lowering db_prescale below the
  // current count ticks on the next edge instead of wrapping through 2^PRE_W.
  assign tick = (pcnt >= db_prescale);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRE_W'(1);
    end
  end

  // Per-pin next-state. A filtered pin only moves once the synchronized level
  // has differed from the output for db_count+1 consecutive ticks; any return
  // to the current output level restarts the qualification, even on a tick.
  always_comb begin
    gpio_in_next = gpio_in;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!db_en[i]) begin
        gpio_in_next[i] = s2[i];
        cnt_next[i]     = '0;
      end else if (s2[i] == gpio_in[i]) begin
        cnt_next[i]     = '0;
      end else if (tick && (cnt[i] >= db_count)) begin
        // >= so that lowering db_count mid-count accepts on the next tick
        gpio_in_next[i] = s2[i];
        cnt_next[i]     = '0;
      end else if (tick) begin
        cnt_next[i]     = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Output level and change pulse are registered together, so the pulse
  // lines up with the first cycle the new level is visible.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gpio_in  <= '0;
      gpio_chg <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      gpio_in  <= gpio_in_next;
      gpio_chg <= gpio_in_next ^ gpio_in;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_gpio_input_filter.sv
// Purpose : checks gpio_input_filter against a behavioural model plus fixed literal expectations.
// Latency : model outputs are compared on every falling edge, half a cycle after the DUT updates.
// Backpressure: none; stimulus is applied on falling edges.
module tb_gpio_input_filter;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] pad_in;
  logic [31:0] db_en;
  logic [15:0] db_prescale;
  logic [7:0]  db_count;
  logic [31:0] gpio_in;
  logic [31:0] gpio_chg;

  int total = 0;
  int bad   = 0;

  gpio_input_filter #(.WIDTH(32), .CNT_W(8), .PRE_W(16)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .pad_in      (pad_in),
    .db_en       (db_en),
    .db_prescale (db_prescale),
    .db_count    (db_count),
    .gpio_in     (gpio_in),
    .gpio_chg    (gpio_chg)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- behavioural model ----------------
  // m_seen1/m_seen2: pad value as seen one and two edges ago.
  // m_since_tick: cycles elapsed since the last sample tick.
  // m_ticks[i]: sample ticks counted while the synced pad continuously
  // disagreed with the output; the (db_count+1)th such tick accepts.
  logic [31:0] m_seen1, m_seen2, m_out, m_chg, m_nxt;
  int          m_since_tick;
  int          m_ticks [32];
  bit          m_tick;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_seen1 = '0;
      m_seen2 = '0;
      m_out   = '0;
      m_chg   = '0;
      m_since_tick = 0;
      for (int i = 0; i < 32; i++) m_ticks[i] = 0;
    end else begin
      m_tick = (m_since_tick >= int'(db_prescale));
      m_nxt  = m_out;
      for (int i = 0; i < 32; i++) begin
        if (!db_en[i]) begin
          m_nxt[i]   = m_seen2[i];
          m_ticks[i] = 0;
        end else if (m_seen2[i] == m_out[i]) begin
          m_ticks[i] = 0;
        end else if (m_tick) begin
          m_ticks[i] = m_ticks[i] + 1;
          if (m_ticks[i] > int'(db_count)) begin
            m_nxt[i]   = m_seen2[i];
            m_ticks[i] = 0;
          end
        end
      end
      m_chg = m_nxt ^ m_out;
      m_out = m_nxt;
      m_since_tick = m_tick ? 0 : m_since_tick + 1;
      m_seen2 = m_seen1;
      m_seen1 = pad_in;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge PCLK) begin
    total++;
    if (gpio_in !== m_out) begin
      bad++;
      $display("FAIL model_gpio_in t=%0t got=%h want=%h", $time, gpio_in, m_out);
    end
    total++;
    if (gpio_chg !== m_chg) begin
      bad++;
      $display("FAIL model_gpio_chg t=%0t got=%h want=%h", $time, gpio_chg, m_chg);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  int  lat;
  bit  found;
  logic [31:0] mask;

  initial begin
    PRESETn     = 1'b0;
    pad_in      = 32'hFFFF_FFFF;
    db_en       = '0;
    db_prescale = '0;
    db_count    = '0;

    // Reset holds outputs low regardless of pads.
    repeat (3) step();
    chk("reset_gpio_in", gpio_in, 32'h0);
    chk("reset_gpio_chg", gpio_chg, 32'h0);

    // Release: all-ones appears on the 3rd edge with a single chg pulse.
    PRESETn = 1'b1;
    step(); chk("rel_edge1", gpio_in, 32'h0);
    step(); chk("rel_edge2", gpio_in, 32'h0);
    step(); chk("rel_edge3_in", gpio_in, 32'hFFFF_FFFF);
            chk("rel_edge3_chg", gpio_chg, 32'hFFFF_FFFF);
    step(); chk("rel_edge4_chg", gpio_chg, 32'h0);

    // Bypass latency on pin 5.
    pad_in = '0;
    repeat (5) step();
    pad_in = 32'h20;
    step(); chk("byp_e1", gpio_in, 32'h0);
    step(); chk("byp_e2", gpio_in, 32'h0);
    step(); chk("byp_e3_in", gpio_in, 32'h20);
            chk("byp_e3_chg", gpio_chg, 32'h20);
    step(); chk("byp_e4_chg", gpio_chg, 32'h0);

    // Debounce accept: prescale 0, count 3 -> rises on the 6th edge from capture.
    db_en = 32'h1; db_prescale = 16'd0; db_count = 8'd3; pad_in = '0;
    repeat (6) step();
    pad_in = 32'h1;
    repeat (5) step();
    chk("db_acc_e5", gpio_in, 32'h0);
    step();
    chk("db_acc_e6_in", gpio_in, 32'h1);
    chk("db_acc_e6_chg", gpio_chg, 32'h1);
    pad_in = '0;
    repeat (10) step();
    chk("db_fall_settled", gpio_in, 32'h0);

    // Debounce reject: 3-cycle pulse never reaches the output.
    pad_in = 32'h1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 2) pad_in = '0;
      chk("db_rej_in", gpio_in, 32'h0);
      chk("db_rej_chg", gpio_chg, 32'h0);
    end

    // 4-cycle pulse is accepted on the 6th edge from capture.
    pad_in = 32'h1;
    repeat (4) step();
    pad_in = '0;
    step();
    chk("db_p4_e5", gpio_in, 32'h0);
    step();
    chk("db_p4_e6", gpio_in, 32'h1);
    repeat (12) step();

    // Prescaler: prescale 4, count 1 -> 2nd tick accepts, 8..12 edges from capture.
    db_en = 32'h80; db_prescale = 16'd4; db_count = 8'd1; pad_in = '0;
    repeat (10) step();
    pad_in = 32'h80;
    found = 0; lat = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (!found && gpio_in[7]) begin
        found = 1;
        lat   = e;
        chk("pre_chg7", gpio_chg, 32'h80);
      end
    end
    total++;
    if (!(found && lat >= 8 && lat <= 12)) begin
      bad++;
      $display("FAIL pre_latency got=%0d want=8..12 (0 = never)", lat);
    end

    // Randomized phase: pads, per-pin mode, prescale and count all vary,
    // including mid-qualification changes and an occasional async reset.
    db_en = $urandom; db_prescale = 16'($urandom_range(0, 4)); db_count = 8'($urandom_range(0, 4));
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c % 250 == 0) begin
        db_en       = $urandom;
        db_prescale = 16'($urandom_range(0, 4));
        db_count    = 8'($urandom_range(0, 4));
      end else if ($urandom_range(0, 60) == 0) begin
        db_prescale = 16'($urandom_range(0, 4));
      end else if ($urandom_range(0, 80) == 0) begin
        db_count = 8'($urandom_range(0, 4));
      end else if ($urandom_range(0, 100) == 0) begin
        db_en = db_en ^ (32'd1 << $urandom_range(0, 31));
      end
      mask = $urandom & $urandom & $urandom;
      if (c[7]) mask = mask & $urandom & $urandom;
      pad_in = pad_in ^ mask;
      if (c % 997 == 500) begin
        #2 PRESETn = 1'b0;
        #4 PRESETn = 1'b1;
      end
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
